// File: rtl/mole_hit_judge.sv
// Whack-a-mole round judge: fetch a target box, light it, time the response, score hits and misses.
// Optional HIT_SPEEDUP_EN shrinks the response window by 1/8 on every hit, floored at MIN_WINDOW.
module mole_hit_judge #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int MIN_WINDOW     = 12_500_000,
    parameter int SCORE_W        = 8,
    parameter int START_LIVES    = 3
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               start,
    input  logic [2:0]         target_box,
    input  logic               hit_valid,
    input  logic [2:0]         hit_box,
    output logic               req_target,
    output logic [3:0]         box_active,
    output logic               result_valid,
    output logic               result_hit,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               game_over
);

    localparam int WMAX = (MIN_WINDOW > TIMEOUT_CYCLES) ? MIN_WINDOW : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(WMAX + 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ARMED,
        S_JUDGE,
        S_OVER
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         tgt_q, tgt_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [TW-1:0]      window_q, window_d;
    logic               hit_q, hit_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [2:0]         tgt_num;

    // Out-of-range selector codes fall back to box 1.
    function automatic logic [1:0] box_idx(input logic [2:0] b);
        logic [1:0] r;
        r = 2'd0;
        if (b >= 3'd1 && b <= 3'd4) begin
            r = 2'(b - 3'd1);
        end
        return r;
    endfunction

    assign tgt_num = {1'b0, tgt_q} + 3'd1;

`ifdef HIT_SPEEDUP_EN
    localparam logic [TW-1:0] MINW = TW'(MIN_WINDOW);
    logic [TW-1:0] win_dec;
    assign win_dec = window_q - (window_q >> 3);
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            tgt_q    <= 2'd0;
            timer_q  <= TMO;
            window_q <= TMO;
            hit_q    <= 1'b0;
            score_q  <= '0;
            lives_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            timer_q  <= timer_d;
            window_q <= window_d;
            hit_q    <= hit_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        timer_d  = timer_q;
        window_d = window_q;
        hit_d    = hit_q;
        score_d  = score_q;
        lives_d  = lives_q;
        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d  = S_FETCH;
                    score_d  = '0;
                    lives_d  = 2'(START_LIVES);
                    window_d = TMO;
                end
            end
            S_FETCH: begin
                tgt_d   = box_idx(target_box);
                timer_d = window_q;
                state_d = S_ARMED;
            end
            S_ARMED: begin
                // A strike on the last window cycle beats the timeout.
                if (hit_valid) begin
                    hit_d   = (hit_box == tgt_num);
                    state_d = S_JUDGE;
                end else if (timer_q <= TW'(1)) begin
                    hit_d   = 1'b0;
                    state_d = S_JUDGE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_JUDGE: begin
                state_d = S_FETCH;
                if (hit_q) begin
                    if (score_q != '1) begin
                        score_d = score_q + 1'b1;
                    end
`ifdef HIT_SPEEDUP_EN
                    window_d = (win_dec < MINW) ? MINW : win_dec;
`endif
                end else begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = S_OVER;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_target   = (state_q == S_FETCH);
    assign box_active   = (state_q == S_ARMED) ? (4'b0001 << tgt_q) : 4'b0000;
    assign result_valid = (state_q == S_JUDGE);
    assign result_hit   = hit_q;
    assign score        = score_q;
    assign lives        = lives_q;
    assign game_over    = (state_q == S_OVER);

endmodule

// File: tb/tb_mole_hit_judge.sv
// Directed bench for mole_hit_judge with a 16-cycle window and three lives.
// Define HIT_SPEEDUP_EN on both files to also exercise the shrinking window.
module tb_mole_hit_judge;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [2:0] target_box;
    logic       hit_valid;
    logic [2:0] hit_box;
    logic       req_target;
    logic [3:0] box_active;
    logic       result_valid;
    logic       result_hit;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    int lat;

    mole_hit_judge #(
        .TIMEOUT_CYCLES(16),
        .MIN_WINDOW    (8),
        .SCORE_W       (8),
        .START_LIVES   (3)
    ) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .start       (start),
        .target_box  (target_box),
        .hit_valid   (hit_valid),
        .hit_box     (hit_box),
        .req_target  (req_target),
        .box_active  (box_active),
        .result_valid(result_valid),
        .result_hit  (result_hit),
        .score       (score),
        .lives       (lives),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in FETCH; leaves in JUDGE. hit_at = ARMED cycle (1-based) of the strike, 0 = none.
    task automatic run_round(input logic [2:0] tbx, input logic [3:0] onehot,
                             input int hit_at, input logic [2:0] hbox,
                             output int n);
        target_box = tbx;
        step();
        check("box_active", 32'(box_active), 32'(onehot));
        n = 0;
        while (!result_valid && n < 64) begin
            if (hit_at > 0 && n == hit_at - 1) begin
                hit_valid = 1'b1;
                hit_box   = hbox;
            end
            step();
            hit_valid = 1'b0;
            n++;
        end
        check("judged", 32'(result_valid), 32'd1);
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        target_box = 3'd0;
        hit_valid  = 1'b0;
        hit_box    = 3'd0;
        step();
        step();
        check("rst_req", 32'(req_target), 32'd0);
        check("rst_box", 32'(box_active), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_rh", 32'(result_hit), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_lives", 32'(lives), 32'd0);
        check("rst_over", 32'(game_over), 32'd0);
        resetn = 1'b1;
        step();
        check("idle_req", 32'(req_target), 32'd0);

        // hit on ARMED cycle 5
        start = 1'b1;
        step();
        start = 1'b0;
        check("fetch_req", 32'(req_target), 32'd1);
        check("fetch_lives", 32'(lives), 32'd3);
        run_round(3'd3, 4'b0100, 5, 3'd3, lat);
        check("t1_lat", 32'(lat), 32'd5);
        check("t1_hit", 32'(result_hit), 32'd1);
        check("t1_box_off", 32'(box_active), 32'd0);
        check("t1_score_judge", 32'(score), 32'd0);
        step();
        check("t1_score", 32'(score), 32'd1);
        check("t1_req", 32'(req_target), 32'd1);

        // timeout
        run_round(3'd2, 4'b0010, 0, 3'd0, lat);
        check("t2_lat", 32'(lat), 32'd16);
        check("t2_hit", 32'(result_hit), 32'd0);
        check("t2_lives_judge", 32'(lives), 32'd3);
        step();
        check("t2_lives", 32'(lives), 32'd2);
        check("t2_score", 32'(score), 32'd1);

        // mismatches until game over
        run_round(3'd4, 4'b1000, 3, 3'd1, lat);
        check("t3a_hit", 32'(result_hit), 32'd0);
        step();
        check("t3a_lives", 32'(lives), 32'd1);
        run_round(3'd4, 4'b1000, 2, 3'd1, lat);
        step();
        check("t3_over", 32'(game_over), 32'd1);
        check("t3_lives", 32'(lives), 32'd0);
        check("t3_score_held", 32'(score), 32'd1);
        check("t3_req", 32'(req_target), 32'd0);
        step();
        check("t3_over_hold", 32'(game_over), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t3_restart_over", 32'(game_over), 32'd0);
        check("t3_restart_score", 32'(score), 32'd0);
        check("t3_restart_lives", 32'(lives), 32'd3);
        check("t3_restart_req", 32'(req_target), 32'd1);
        for (int i = 0; i < 3; i++) begin
            run_round(3'd4, 4'b1000, 1, 3'd1, lat);
            check("t3_miss", 32'(result_hit), 32'd0);
            step();
        end
        check("t3b_over", 32'(game_over), 32'd1);
        check("t3b_lives", 32'(lives), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;

        // strike on final window cycle, out-of-range targets
        run_round(3'd7, 4'b0001, 16, 3'd1, lat);
        check("t4_lat", 32'(lat), 32'd16);
        check("t4_hit", 32'(result_hit), 32'd1);
        step();
        check("t4_score", 32'(score), 32'd1);
        run_round(3'd0, 4'b0001, 2, 3'd2, lat);
        check("t4_mis_hit", 32'(result_hit), 32'd0);
        step();
        check("t4_lives", 32'(lives), 32'd2);

        // reset mid-round, then stray hit in IDLE
        target_box = 3'd1;
        step();
        step();
        check("t5_armed", 32'(box_active), 32'b0001);
        resetn = 1'b0;
        #1;
        check("t5_box", 32'(box_active), 32'd0);
        check("t5_rv", 32'(result_valid), 32'd0);
        check("t5_score", 32'(score), 32'd0);
        check("t5_lives", 32'(lives), 32'd0);
        check("t5_rh", 32'(result_hit), 32'd0);
        step();
        check("t5_rv_hold", 32'(result_valid), 32'd0);
        resetn    = 1'b1;
        hit_valid = 1'b1;
        hit_box   = 3'd1;
        step();
        hit_valid = 1'b0;
        check("t5_idle_score", 32'(score), 32'd0);
        check("t5_idle_req", 32'(req_target), 32'd0);
        check("t5_idle_rv", 32'(result_valid), 32'd0);
        step();
        check("t5_idle_rv2", 32'(result_valid), 32'd0);
        check("t5_idle_box", 32'(box_active), 32'd0);

`ifdef HIT_SPEEDUP_EN
        begin
            int wins[9] = '{16, 14, 13, 12, 11, 10, 9, 8, 8};
            start = 1'b1;
            step();
            start = 1'b0;
            for (int i = 0; i < 9; i++) begin
                run_round(3'd1, 4'b0001, wins[i], 3'd1, lat);
                check("t6_lat", 32'(lat), 32'(wins[i]));
                check("t6_hit", 32'(result_hit), 32'd1);
                step();
            end
            run_round(3'd1, 4'b0001, 0, 3'd0, lat);
            check("t6_floor", 32'(lat), 32'd8);
            step();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
